// File: rtl/fde_pkg.sv
// Shared fetch/decode/execute definitions: sequencer state encodings and opcode
// classification used by the fetch and decode stages.
package fde_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_MEM = 3'd2,
    ST_DECODE   = 3'd3,
    ST_EXECUTE  = 3'd4,
    ST_HALT     = 3'd5
  } state_t;

  localparam logic [3:0] OPC_HALT     = 4'hF;
  localparam int         OPC_LONG_BIT = 3;

  function automatic logic is_long_op(input logic [3:0] opcode);
    return opcode[OPC_LONG_BIT];
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter with synchronous active-low clear; sticks at all-ones
// instead of wrapping.
module sat_counter16 (
  input  logic        i_clk,
  input  logic        i_clear_n,
  input  logic        i_en,
  output logic [15:0] o_count
);

  logic [15:0] count;
  logic [15:0] count_next;

  always_comb begin
    count_next = count;
    if (i_en && (count != 16'hFFFF)) begin
      count_next = count + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_clear_n) begin
      count <= 16'd0;
    end else begin
      count <= count_next;
    end
  end

  assign o_count = count;

endmodule

// File: rtl/fde_sequencer.sv
// Moore fetch/decode/execute sequencer: paces the PC and stage enables one
// instruction at a time and counts retired instructions.
module fde_sequencer
  import fde_pkg::*;
#(
  parameter int         EXEC_LONG = 2,
  parameter logic [3:0] OP_HALT   = OPC_HALT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_pause,
  input  logic        i_mem_ready,
  input  logic [3:0]  i_opcode,
  output logic        o_stop,
  output logic        o_fetch_en,
  output logic        o_decode_en,
  output logic        o_exec_en,
  output logic        o_halted,
  output logic [2:0]  o_state,
  output logic [15:0] o_instr_cnt
);

  localparam int EXEC_W = (EXEC_LONG > 1) ? $clog2(EXEC_LONG + 1) : 1;
  localparam logic [EXEC_W-1:0] EXEC_LOAD = EXEC_W'(EXEC_LONG);

  state_t            state;
  state_t            state_next;
  logic [EXEC_W-1:0] exec_cnt;
  logic [EXEC_W-1:0] exec_cnt_next;
  logic              retire;

  assign retire = (state == ST_EXECUTE) && (exec_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state    <= ST_IDLE;
      exec_cnt <= '0;
    end else begin
      state    <= state_next;
      exec_cnt <= exec_cnt_next;
    end
  end

  // The exec counter holds the number of execute cycles still owed after this one.
  always_comb begin
    state_next    = state;
    exec_cnt_next = exec_cnt;
    unique case (state)
      ST_IDLE: begin
        if (i_start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        state_next = ST_WAIT_MEM;
      end
      ST_WAIT_MEM: begin
        if (i_mem_ready) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (i_opcode == OP_HALT) begin
          state_next = ST_HALT;
        end else begin
          state_next    = ST_EXECUTE;
          exec_cnt_next = is_long_op(i_opcode) ? EXEC_LOAD : '0;
        end
      end
      ST_EXECUTE: begin
        if (exec_cnt != '0) begin
          exec_cnt_next = exec_cnt - EXEC_W'(1);
        end else begin
          state_next = i_pause ? ST_IDLE : ST_FETCH;
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    o_stop      = (state != ST_FETCH);
    o_fetch_en  = (state == ST_FETCH);
    o_decode_en = (state == ST_DECODE);
    o_exec_en   = (state == ST_EXECUTE);
    o_halted    = (state == ST_HALT);
    o_state     = state;
  end

  sat_counter16 u_instr_cnt (
    .i_clk     (i_clk),
    .i_clear_n (i_reset),
    .i_en      (retire),
    .o_count   (o_instr_cnt)
  );

endmodule

// File: tb/tb_fde_sequencer.sv
// Bench for fde_sequencer: directed sequences with literal checkpoints plus a
// per-cycle comparison against an instruction-level reference model.
module tb_fde_sequencer;

  localparam int EXEC_LONG = 2;

  localparam int M_IDLE = 0, M_FETCH = 1, M_WAIT = 2, M_DECODE = 3, M_EXEC = 4, M_HALT = 5;

  logic        clk;
  logic        i_reset;
  logic        i_start;
  logic        i_pause;
  logic        i_mem_ready;
  logic [3:0]  i_opcode;
  logic        o_stop;
  logic        o_fetch_en;
  logic        o_decode_en;
  logic        o_exec_en;
  logic        o_halted;
  logic [2:0]  o_state;
  logic [15:0] o_instr_cnt;

  int checks = 0;
  int errors = 0;

  int          m_state = M_IDLE;
  int          m_left  = 0;
  logic [15:0] m_cnt   = 16'd0;
  bit          m_valid = 1'b0;

  fde_sequencer #(.EXEC_LONG(EXEC_LONG), .OP_HALT(4'hF)) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_pause     (i_pause),
    .i_mem_ready (i_mem_ready),
    .i_opcode    (i_opcode),
    .o_stop      (o_stop),
    .o_fetch_en  (o_fetch_en),
    .o_decode_en (o_decode_en),
    .o_exec_en   (o_exec_en),
    .o_halted    (o_halted),
    .o_state     (o_state),
    .o_instr_cnt (o_instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exec_len(input logic [3:0] op);
    return op[3] ? EXEC_LONG + 1 : 1;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic start, input logic pause,
                               input logic ready, input logic [3:0] op, input int n);
    i_reset     = rst;
    i_start     = start;
    i_pause     = pause;
    i_mem_ready = ready;
    i_opcode    = op;
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Instruction-level model: an instruction occupies exec_len cycles of execute.
  always @(posedge clk) begin
    if (!i_reset) begin
      m_state = M_IDLE;
      m_left  = 0;
      m_cnt   = 16'd0;
      m_valid = 1'b1;
    end else begin
      case (m_state)
        M_IDLE:   if (i_start) m_state = M_FETCH;
        M_FETCH:  m_state = M_WAIT;
        M_WAIT:   if (i_mem_ready) m_state = M_DECODE;
        M_DECODE: begin
          if (i_opcode == 4'hF) m_state = M_HALT;
          else begin
            m_state = M_EXEC;
            m_left  = exec_len(i_opcode);
          end
        end
        M_EXEC: begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_state = i_pause ? M_IDLE : M_FETCH;
          end
        end
        default: m_state = M_HALT;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("state",     {13'd0, o_state},     16'(m_state));
      checkOutput("stop",      {15'd0, o_stop},      {15'd0, m_state != M_FETCH});
      checkOutput("fetch_en",  {15'd0, o_fetch_en},  {15'd0, m_state == M_FETCH});
      checkOutput("decode_en", {15'd0, o_decode_en}, {15'd0, m_state == M_DECODE});
      checkOutput("exec_en",   {15'd0, o_exec_en},   {15'd0, m_state == M_EXEC});
      checkOutput("halted",    {15'd0, o_halted},    {15'd0, m_state == M_HALT});
      checkOutput("instr_cnt", o_instr_cnt,          m_cnt);
    end
  end

  initial begin
    int n_fetch;
    int n_exec;

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 2);
    checkOutput("rst_state",  {13'd0, o_state}, 16'd0);
    checkOutput("rst_stop",   {15'd0, o_stop}, 16'd1);
    checkOutput("rst_enables", {13'd0, o_fetch_en, o_decode_en, o_exec_en}, 16'd0);
    checkOutput("rst_halted", {15'd0, o_halted}, 16'd0);
    checkOutput("rst_cnt",    o_instr_cnt, 16'd0);

    // Short opcode back-to-back: one PC advance per 4 cycles
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'h1, 1);
    checkOutput("start_fetch", {13'd0, o_state}, 16'd1);
    n_fetch = (o_stop == 1'b0) ? 1 : 0;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 1);
      if (o_stop == 1'b0) n_fetch++;
    end
    checkOutput("short_stop_low", 16'(n_fetch), 16'd3);
    checkOutput("short_state12", {13'd0, o_state}, 16'd4);
    checkOutput("short_cnt12", o_instr_cnt, 16'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 1);
    checkOutput("short_cnt13", o_instr_cnt, 16'd3);

    // Long opcode: 3 execute cycles, 6-cycle period
    n_fetch = 0;
    n_exec  = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h9, 1);
      if (o_exec_en) n_exec++;
      if (o_fetch_en) n_fetch++;
    end
    checkOutput("long_exec_cycles", 16'(n_exec), 16'd6);
    checkOutput("long_fetches", 16'(n_fetch), 16'd2);
    checkOutput("long_cnt", o_instr_cnt, 16'd5);

    // Memory stall in WAIT_MEM
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 1);
      checkOutput("stall_state", {13'd0, o_state}, 16'd2);
      checkOutput("stall_stop", {15'd0, o_stop}, 16'd1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 1);
    checkOutput("stall_decode", {13'd0, o_state}, 16'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 2);
    checkOutput("stall_cnt", o_instr_cnt, 16'd6);

    // Pause ignored mid-execute, honoured on retire; reset glitch between edges
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h9, 3);
    checkOutput("pause_exec1", {13'd0, o_state}, 16'd4);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'h9, 1);
    checkOutput("pause_exec2", {13'd0, o_state}, 16'd4);
    i_reset = 1'b0;
    #2;
    i_reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h9, 1);
    checkOutput("pause_exec3", {13'd0, o_state}, 16'd4);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'h9, 1);
    checkOutput("pause_idle", {13'd0, o_state}, 16'd0);
    checkOutput("pause_cnt", o_instr_cnt, 16'd7);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'h9, 2);
    checkOutput("pause_stay_idle", {13'd0, o_state}, 16'd0);

    // Pause and start together on retire: IDLE then FETCH
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'h1, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 3);
    checkOutput("both_exec", {13'd0, o_state}, 16'd4);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 1);
    checkOutput("both_idle", {13'd0, o_state}, 16'd0);
    checkOutput("both_cnt", o_instr_cnt, 16'd8);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 1);
    checkOutput("both_fetch", {13'd0, o_state}, 16'd1);

    // HALT: not counted, start ignored, left only by reset
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 3);
    checkOutput("halt_state", {13'd0, o_state}, 16'd5);
    checkOutput("halt_flag", {15'd0, o_halted}, 16'd1);
    checkOutput("halt_cnt", o_instr_cnt, 16'd8);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'h1, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 1);
    end
    checkOutput("halt_sticky", {13'd0, o_state}, 16'd5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 1);
    checkOutput("halt_rst_state", {13'd0, o_state}, 16'd0);
    checkOutput("halt_rst_flag", {15'd0, o_halted}, 16'd0);
    checkOutput("halt_rst_cnt", o_instr_cnt, 16'd0);

    // Saturation near the top of the counter range
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 1);
    force dut.u_instr_cnt.count = 16'hFFFE;
    m_cnt = 16'hFFFE;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 1);
    release dut.u_instr_cnt.count;
    checkOutput("sat_preload", o_instr_cnt, 16'hFFFE);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'h1, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 12);
    checkOutput("sat_state", {13'd0, o_state}, 16'd1);
    checkOutput("sat_cnt", o_instr_cnt, 16'hFFFF);

    // Reset in the middle of a long execute
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h9, 4);
    checkOutput("midexec_state", {13'd0, o_state}, 16'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h9, 1);
    checkOutput("midexec_rst_state", {13'd0, o_state}, 16'd0);
    checkOutput("midexec_rst_cnt", o_instr_cnt, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
